// File: rtl/powerup_manager.sv
// powerup_manager
// Powerup engine for the Pacman game fabric. Tracks NUM_POWERUPS collectible
// powerups against NUM_PLAYERS player positions, detects pickups by box
// overlap, grants a timed effect flag to the collecting player and exposes a
// small memory-mapped register window to the processor.
//
// Ports:
//   clock      - single clock, all state on the rising edge
//   reset      - asynchronous, active-high
//   player_x/y - flattened player coordinates, player p at [p*COORD_W +: COORD_W]
//   addr       - processor dmem address (17 bits)
//   wren/wdata - processor write strobe and data
//   rdata      - registered read data (one cycle latency)
//   rd_hit     - registered, high when rdata belongs to a dedicated address
//   powerup_x/y- flattened powerup coordinates, all-ones while hidden
//   effect     - bit p*NUM_POWERUPS+u set while player p holds powerup u
//
// Register window (offsets from BASE_ADDR):
//   p          read : effect bits of player p
//   16+2u      read : powerup u x, write: home x of powerup u (re-places it)
//   16+2u+1    read : powerup u y, write: home y of powerup u (re-places it)
//
// Build option: define POWERUP_RESPAWN_EN to have an expired powerup wait
// RESPAWN_TICKS cycles in COOLDOWN and then reappear at home. Without it an
// expired powerup stays consumed (hidden) until the processor re-places it.

module powerup_manager #(
  parameter int NUM_PLAYERS     = 2,
  parameter int NUM_POWERUPS    = 2,
  parameter int COORD_W         = 32,
  parameter int SIZE            = 32,
  parameter int TICKS_PER_STAGE = 100000000,
  parameter int NUM_STAGES      = 7,
  parameter int RESPAWN_TICKS   = 500000000,
  parameter int HOME_BASE       = 300,
  parameter int HOME_STEP       = 100,
  parameter int BASE_ADDR       = 4300
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_PLAYERS*COORD_W-1:0]    player_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0]    player_y,
  input  logic [16:0]                       addr,
  input  logic                              wren,
  input  logic [31:0]                       wdata,
  output logic [31:0]                       rdata,
  output logic                              rd_hit,
  output logic [NUM_POWERUPS*COORD_W-1:0]   powerup_x,
  output logic [NUM_POWERUPS*COORD_W-1:0]   powerup_y,
  output logic [NUM_PLAYERS*NUM_POWERUPS-1:0] effect
);

  localparam int PIDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CW1    = COORD_W + 1;
  localparam logic [16:0]  BASE     = 17'(BASE_ADDR);
  localparam logic [CW1-1:0] SIZE_EXT = CW1'(SIZE);

  // CONSUMED is the hidden, collision-inhibited condition an expired powerup
  // sits in when respawn is not built in.
  typedef enum logic [1:0] {
    VISIBLE,
    HELD,
    COOLDOWN,
    CONSUMED
  } state_t;

  state_t              state      [NUM_POWERUPS];
  state_t              next_state [NUM_POWERUPS];
  logic [31:0]         tick       [NUM_POWERUPS];
  logic [31:0]         next_tick  [NUM_POWERUPS];
  logic [31:0]         stage      [NUM_POWERUPS];
  logic [31:0]         next_stage [NUM_POWERUPS];
  logic [PIDX_W-1:0]   owner      [NUM_POWERUPS];
  logic [PIDX_W-1:0]   next_owner [NUM_POWERUPS];
  logic [COORD_W-1:0]  home_x     [NUM_POWERUPS];
  logic [COORD_W-1:0]  home_y     [NUM_POWERUPS];
  logic [COORD_W-1:0]  next_home_x[NUM_POWERUPS];
  logic [COORD_W-1:0]  next_home_y[NUM_POWERUPS];

  logic                hit_any    [NUM_POWERUPS];
  logic [PIDX_W-1:0]   hit_owner  [NUM_POWERUPS];

  logic                in_range;
  logic [16:0]         offset;
  logic [31:0]         next_rdata;
  logic                next_rd_hit;

  assign in_range = (addr >= BASE);
  assign offset   = addr - BASE;

  // One axis of the box test, widened by a bit so a + SIZE never wraps.
  function automatic logic overlap(input logic [COORD_W-1:0] a,
                                   input logic [COORD_W-1:0] b);
    logic [CW1-1:0] ae;
    logic [CW1-1:0] be;
    ae = {1'b0, a};
    be = {1'b0, b};
    return (ae + SIZE_EXT >= be) && (ae <= be + SIZE_EXT);
  endfunction

  // Pickup detection. Players are scanned from the highest index down so the
  // lowest colliding index is the one left in hit_owner.
  always_comb begin
    for (int u = 0; u < NUM_POWERUPS; u++) begin
      hit_any[u]   = 1'b0;
      hit_owner[u] = '0;
      for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
        if (overlap(player_x[p*COORD_W +: COORD_W], home_x[u]) &&
            overlap(player_y[p*COORD_W +: COORD_W], home_y[u])) begin
          hit_any[u]   = 1'b1;
          hit_owner[u] = PIDX_W'(p);
        end
      end
    end
  end

  // Per-powerup next state. A processor write to either home register takes
  // priority over everything else and drops the powerup back to VISIBLE.
  always_comb begin
    for (int u = 0; u < NUM_POWERUPS; u++) begin
      next_state[u]  = state[u];
      next_tick[u]   = tick[u];
      next_stage[u]  = stage[u];
      next_owner[u]  = owner[u];
      next_home_x[u] = home_x[u];
      next_home_y[u] = home_y[u];

      if (wren && in_range &&
          (offset == 17'(16 + 2*u) || offset == 17'(17 + 2*u))) begin
        if (offset == 17'(16 + 2*u)) begin
          next_home_x[u] = COORD_W'(wdata);
        end else begin
          next_home_y[u] = COORD_W'(wdata);
        end
        next_state[u] = VISIBLE;
        next_tick[u]  = '0;
        next_stage[u] = '0;
      end else begin
        case (state[u])
          VISIBLE: begin
            if (hit_any[u]) begin
              next_state[u] = HELD;
              next_owner[u] = hit_owner[u];
              next_tick[u]  = '0;
              next_stage[u] = '0;
            end
          end
          HELD: begin
            if (tick[u] == 32'(TICKS_PER_STAGE - 1)) begin
              next_tick[u] = '0;
              if (stage[u] == 32'(NUM_STAGES - 1)) begin
                next_stage[u] = '0;
`ifdef POWERUP_RESPAWN_EN
                next_state[u] = COOLDOWN;
`else
                next_state[u] = CONSUMED;
`endif
              end else begin
                next_stage[u] = stage[u] + 32'd1;
              end
            end else begin
              next_tick[u] = tick[u] + 32'd1;
            end
          end
          COOLDOWN: begin
            // Only entered when respawn is built in; reuses the tick counter.
            if (tick[u] == 32'(RESPAWN_TICKS - 1)) begin
              next_tick[u]  = '0;
              next_state[u] = VISIBLE;
            end else begin
              next_tick[u] = tick[u] + 32'd1;
            end
          end
          default: begin
            next_state[u] = CONSUMED;
          end
        endcase
      end
    end
  end

  // State register. Reset restores the parameter homes, discarding any
  // homes the processor wrote.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int u = 0; u < NUM_POWERUPS; u++) begin
        state[u]  <= VISIBLE;
        tick[u]   <= '0;
        stage[u]  <= '0;
        owner[u]  <= '0;
        home_x[u] <= COORD_W'(HOME_BASE + u*HOME_STEP);
        home_y[u] <= COORD_W'(HOME_BASE + u*HOME_STEP);
      end
    end else begin
      for (int u = 0; u < NUM_POWERUPS; u++) begin
        state[u]  <= next_state[u];
        tick[u]   <= next_tick[u];
        stage[u]  <= next_stage[u];
        owner[u]  <= next_owner[u];
        home_x[u] <= next_home_x[u];
        home_y[u] <= next_home_y[u];
      end
    end
  end

  // A visible powerup always sits at its home, so the coordinates are the
  // home registers masked to all-ones whenever it is not visible.
  always_comb begin
    powerup_x = '0;
    powerup_y = '0;
    effect    = '0;
    for (int u = 0; u < NUM_POWERUPS; u++) begin
      powerup_x[u*COORD_W +: COORD_W] = (state[u] == VISIBLE) ? home_x[u] : '1;
      powerup_y[u*COORD_W +: COORD_W] = (state[u] == VISIBLE) ? home_y[u] : '1;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        effect[p*NUM_POWERUPS + u] = (state[u] == HELD) &&
                                     (owner[u] == PIDX_W'(p));
      end
    end
  end

  // Read decode. Only plain reads (wren low) produce a hit.
  always_comb begin
    next_rdata  = '0;
    next_rd_hit = 1'b0;
    if (!wren && in_range) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (offset == 17'(p)) begin
          next_rd_hit = 1'b1;
          next_rdata  = 32'(effect[p*NUM_POWERUPS +: NUM_POWERUPS]);
        end
      end
      for (int u = 0; u < NUM_POWERUPS; u++) begin
        if (offset == 17'(16 + 2*u)) begin
          next_rd_hit = 1'b1;
          next_rdata  = 32'(powerup_x[u*COORD_W +: COORD_W]);
        end
        if (offset == 17'(17 + 2*u)) begin
          next_rd_hit = 1'b1;
          next_rdata  = 32'(powerup_y[u*COORD_W +: COORD_W]);
        end
      end
    end
  end

  // Registered read port, one cycle behind the address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rd_hit <= 1'b0;
    end else begin
      rdata  <= next_rdata;
      rd_hit <= next_rd_hit;
    end
  end

endmodule

// File: doc/powerup_manager.md
# powerup_manager

Parametrised powerup engine for the Pacman game fabric. It tracks NUM_POWERUPS collectible powerups against NUM_PLAYERS player positions and detects pickups by box overlap. On pickup it hides the powerup, grants a timed effect flag to the collecting player, and optionally respawns the powerup after a cooldown. It sits beside the processor's dedicated-address decode: the processor reads effect flags through a memory-mapped read port and re-places powerups through a write port, while the VGA path consumes the powerup coordinates directly.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of players checked for collision
- NUM_POWERUPS, 2, number of independent powerups
- COORD_W, 32, coordinate width
- SIZE, 32, sprite edge length in pixels (players and powerups)
- TICKS_PER_STAGE, 100000000, clock cycles per effect stage
- NUM_STAGES, 7, stages per effect; effect length is NUM_STAGES*TICKS_PER_STAGE cycles
- RESPAWN_TICKS, 500000000, cooldown before respawn (macro-gated)
- HOME_BASE, 300, home x and y of powerup 0
- HOME_STEP, 100, home x/y increment per powerup index
- BASE_ADDR, 4300, first dedicated address (17-bit)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- player_x  in  NUM_PLAYERS*COORD_W  flattened; player p at [p*COORD_W +: COORD_W]
- player_y  in  NUM_PLAYERS*COORD_W  same packing
- addr  in  17  processor dmem address
- wren  in  1  write strobe
- wdata  in  32  write data
- rdata  out  32  registered read data
- rd_hit  out  1  registered; rdata valid for a dedicated address
- powerup_x  out  NUM_POWERUPS*COORD_W  flattened; all-ones when hidden
- powerup_y  out  NUM_POWERUPS*COORD_W  same
- effect  out  NUM_PLAYERS*NUM_POWERUPS  bit p*NUM_POWERUPS+u means player p holds powerup u

## Operation
- Per-powerup FSM: VISIBLE, HELD, COOLDOWN (COOLDOWN is only reachable with the macro).
- Collision for player p and powerup u: (px+SIZE >= ux) && (px <= ux+SIZE), same for y. Sums are evaluated in COORD_W+1 bits so no wrap occurs. Collision is only evaluated in VISIBLE.
- VISIBLE plus collision leads to HELD: coords go to all-ones, the owner is latched, the effect bit is set, and tick and stage clear. If several players collide on the same cycle, the lowest player index wins.
- HELD: tick counts 0..TICKS_PER_STAGE-1. On tick wrap, stage increments. On wrap with stage==NUM_STAGES-1 the effect bit clears and the FSM leaves HELD.
- A player may hold several distinct powerups at once. Timers are independent per powerup.
- Register map, relative to BASE_ADDR:
  - Read offset p (p<NUM_PLAYERS): {zero-pad, that player's NUM_POWERUPS effect bits}.
  - Read offset 16+2u: powerup u x. Read offset 16+2u+1: powerup u y.
  - Write offset 16+2u: sets home x. Write offset 16+2u+1: sets home y. Either write immediately re-places powerup u at its home coords in VISIBLE, clears any effect it granted, and clears its timers.
- A write and a collision on the same powerup in the same cycle: the write wins.
- Reads outside the map: rd_hit=0, rdata=0. Writes outside the map are ignored.

## Timing
- Reset (async) values:
  - powerup u coords: HOME_BASE+u*HOME_STEP; home registers take the same value.
  - State VISIBLE; effect=0, rdata=0, rd_hit=0, all counters 0.
- Pickup latency: collision visible at edge N produces hidden coords and the effect bit after edge N.
- Effect is high for exactly NUM_STAGES*TICKS_PER_STAGE cycles.
- Read latency: one cycle. addr is sampled with wren=0 at edge N; rdata and rd_hit are valid after edge N.
- Write takes effect at the sampling edge and is visible on outputs after it.
- Reset mid-effect clears everything immediately and returns the powerup to its parameter home, not the written home.

## Configuration
- POWERUP_RESPAWN_EN defined: on expiry, HELD moves to COOLDOWN. The powerup stays hidden for RESPAWN_TICKS cycles, then returns to VISIBLE at its home coords. Counters are reused.
- POWERUP_RESPAWN_EN undefined: on expiry, HELD moves to a consumed VISIBLE-inhibited condition. Coords stay all-ones until a processor write re-places the powerup. The COOLDOWN state and RESPAWN_TICKS are unused.

## Test plan
All scenarios use NUM_PLAYERS=2, NUM_POWERUPS=2, TICKS_PER_STAGE=4, NUM_STAGES=3, RESPAWN_TICKS=5.
- Reset: powerup 0 at (300,300), powerup 1 at (400,400); effect=0; read BASE_ADDR+16 returns 300 one cycle later with rd_hit=1.
- Player 0 at (290,310): next edge, powerup 0 coords are all-ones and effect[0]=1; effect[0] stays high for 12 cycles, then clears.
- Players 0 and 1 both overlap powerup 1 on the same cycle: only effect[1] (player 0) is set; effect[3] stays 0.
- Edge case: player at (332,300) against powerup 0 at (300,300) collides; player at (333,300) does not.
- Write 50 to BASE_ADDR+16 during HELD: powerup 0 becomes visible at (50,300) and effect[0] clears on the same edge. Collision on the same cycle is ignored.
- With the macro, after expiry powerup 0 reappears at home after 5 cycles. Without it, powerup 0 stays all-ones indefinitely.
